// File: rtl/register_file_scoreboard_if.sv
// Decode/writeback bundle for register_file_scoreboard: read ports, write ports,
// scoreboard claim and the clear-sequencer busy flag.
interface register_file_scoreboard_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 16,
    parameter int NUM_READ_PORTS  = 3,
    parameter int NUM_WRITE_PORTS = 2
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic [NUM_READ_PORTS*SEL_W-1:0]        read_sel;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   read_data;
    logic [NUM_READ_PORTS-1:0]              read_pending;
    logic [NUM_WRITE_PORTS-1:0]             write_en;
    logic [NUM_WRITE_PORTS*SEL_W-1:0]       write_sel;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0]  write_data;
    logic                                   claim_en;
    logic [SEL_W-1:0]                       claim_sel;
    logic                                   busy;

    modport master (
        output read_sel, write_en, write_sel, write_data, claim_en, claim_sel,
        input  read_data, read_pending, busy
    );

    modport slave (
        input  read_sel, write_en, write_sel, write_data, claim_en, claim_sel,
        output read_data, read_pending, busy
    );
endinterface

// File: rtl/register_file_scoreboard.sv
// Multi-port register file with pending scoreboard, write bypass and a post-reset
// clear sequencer. Define REGISTER_FILE_SCOREBOARD_READ_STAGE_EN to register the read outputs.
module register_file_scoreboard #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 16,
    parameter int NUM_READ_PORTS  = 3,
    parameter int NUM_WRITE_PORTS = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    register_file_scoreboard_if.slave rf
);
    localparam int SEL_W = $clog2(NUM_REGS);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REGS - 1);
    localparam logic [SEL_W-1:0] FIRST_IDX = SEL_W'(1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [SEL_W-1:0]      clr_idx;
    logic [NUM_REGS-1:0]   pending;
    logic                  busy;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [SEL_W-1:0]      wsel  [NUM_WRITE_PORTS];
    logic [DATA_WIDTH-1:0] wdata [NUM_WRITE_PORTS];
    logic [SEL_W-1:0]      rsel  [NUM_READ_PORTS];
    logic [NUM_WRITE_PORTS-1:0] wr_eff;
    logic                  claim_eff;

    logic [DATA_WIDTH-1:0] rd_data [NUM_READ_PORTS];
    logic [NUM_READ_PORTS-1:0]            rd_pend;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data_flat;

    always_comb begin
        wsel   = '{default: '0};
        wdata  = '{default: '0};
        rsel   = '{default: '0};
        wr_eff = '0;
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            wsel[w]   = rf.write_sel[w*SEL_W +: SEL_W];
            wdata[w]  = rf.write_data[w*DATA_WIDTH +: DATA_WIDTH];
            wr_eff[w] = (state == READY) && rf.write_en[w] && (wsel[w] != '0);
        end
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rsel[p] = rf.read_sel[p*SEL_W +: SEL_W];
        end
        claim_eff = (state == READY) && rf.claim_en && (rf.claim_sel != '0);
    end

    // Sequencer and scoreboard; the claim is applied after the write clears so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= FIRST_IDX;
            pending <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                READY: begin
                    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                        if (wr_eff[w]) pending[wsel[w]] <= 1'b0;
                    end
                    if (claim_eff) pending[rf.claim_sel] <= 1'b1;
                end
            endcase
        end
    end

    // The array has no reset; it is zeroed by the sequencer. Higher write ports win.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[clr_idx] <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                if (wr_eff[w]) regs[wsel[w]] <= wdata[w];
            end
        end
    end

    always_comb begin
        rd_data      = '{default: '0};
        rd_pend      = '0;
        rd_data_flat = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if ((state == READY) && (rsel[p] != '0)) begin
                rd_data[p] = regs[rsel[p]];
                rd_pend[p] = pending[rsel[p]];
                for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                    if (wr_eff[w] && (wsel[w] == rsel[p])) begin
                        rd_data[p] = wdata[w];
                        rd_pend[p] = claim_eff && (rf.claim_sel == rsel[p]);
                    end
                end
            end
            rd_data_flat[p*DATA_WIDTH +: DATA_WIDTH] = rd_data[p];
        end
    end

    assign rf.busy = busy;

`ifdef REGISTER_FILE_SCOREBOARD_READ_STAGE_EN
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data_p1;
    logic [NUM_READ_PORTS-1:0]            read_pending_p1;

    // Read stage: samples the bypassed values, zero throughout CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_p1    <= '0;
            read_pending_p1 <= '0;
        end else begin
            read_data_p1    <= rd_data_flat;
            read_pending_p1 <= rd_pend;
        end
    end

    assign rf.read_data    = read_data_p1;
    assign rf.read_pending = read_pending_p1;
`else
    assign rf.read_data    = rd_data_flat;
    assign rf.read_pending = rd_pend;
`endif

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Randomized bench for register_file_scoreboard against an array/scoreboard model,
// with directed bypass, collision, claim and reset-restart cases.
module tb_register_file_scoreboard;
    localparam int DW  = 32;
    localparam int NR  = 16;
    localparam int NRP = 3;
    localparam int NWP = 2;
    localparam int SW  = $clog2(NR);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    register_file_scoreboard_if #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP)
    ) bus ();

    register_file_scoreboard #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];
    int            m_clear_left;
    logic [DW-1:0] exp_data [NRP];
    bit            exp_pend [NRP];
    logic [DW-1:0] obs_data0;
    logic          obs_pend0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_clear_left = NR - 1;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
    endfunction

    function automatic logic [SW-1:0] wr_sel(input int w);
        return bus.write_sel[w*SW +: SW];
    endfunction

    function automatic logic [DW-1:0] wr_dat(input int w);
        return bus.write_data[w*DW +: DW];
    endfunction

    // Expected read outputs for the inputs currently applied.
    function automatic void model_expect();
        for (int p = 0; p < NRP; p++) begin
            logic [SW-1:0] sel;
            bit hit;
            sel = bus.read_sel[p*SW +: SW];
            exp_data[p] = '0;
            exp_pend[p] = 1'b0;
            hit = 1'b0;
            if (m_clear_left == 0 && sel != 0) begin
                exp_data[p] = m_regs[sel];
                for (int w = 0; w < NWP; w++) begin
                    if (bus.write_en[w] && wr_sel(w) == sel) begin
                        hit = 1'b1;
                        exp_data[p] = wr_dat(w);
                    end
                end
                exp_pend[p] = hit ? (bus.claim_en && bus.claim_sel == sel) : m_pend[sel];
            end
        end
    endfunction

    // State change at a clock edge with rst_n high.
    function automatic void model_edge();
        if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0) foreach (m_regs[i]) m_regs[i] = '0;
        end else begin
            for (int w = 0; w < NWP; w++) begin
                if (bus.write_en[w] && wr_sel(w) != 0) begin
                    m_regs[wr_sel(w)] = wr_dat(w);
                    m_pend[wr_sel(w)] = 1'b0;
                end
            end
            if (bus.claim_en && bus.claim_sel != 0) m_pend[bus.claim_sel] = 1'b1;
        end
    endfunction

    task automatic compare_reads();
        for (int p = 0; p < NRP; p++) begin
            check($sformatf("read_data%0d", p), 64'(bus.read_data[p*DW +: DW]), 64'(exp_data[p]));
            check($sformatf("read_pending%0d", p), 64'(bus.read_pending[p]), 64'(exp_pend[p]));
        end
        obs_data0 = bus.read_data[DW-1:0];
        obs_pend0 = bus.read_pending[0];
    endtask

    // Entered just after a falling edge with inputs applied; leaves at the next falling edge.
    task automatic cycle();
        #1;
        model_expect();
        check("busy", 64'(bus.busy), 64'(m_clear_left > 0));
`ifndef REGISTER_FILE_SCOREBOARD_READ_STAGE_EN
        compare_reads();
`endif
        @(posedge clk);
        if (rst_n) model_edge();
`ifdef REGISTER_FILE_SCOREBOARD_READ_STAGE_EN
        #1;
        compare_reads();
`endif
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.read_sel   = '0;
        bus.write_en   = '0;
        bus.write_sel  = '0;
        bus.write_data = '0;
        bus.claim_en   = 1'b0;
        bus.claim_sel  = '0;
    endtask

    task automatic rand_inputs();
        for (int p = 0; p < NRP; p++) bus.read_sel[p*SW +: SW] = SW'($urandom_range(0, NR - 1));
        bus.write_en = NWP'($urandom);
        for (int w = 0; w < NWP; w++) begin
            bus.write_sel[w*SW +: SW]  = ($urandom_range(0, 3) == 0) ? bus.read_sel[SW-1:0]
                                                                     : SW'($urandom_range(0, NR - 1));
            bus.write_data[w*DW +: DW] = DW'($urandom);
        end
        if ($urandom_range(0, 3) == 0) bus.write_sel[SW +: SW] = bus.write_sel[SW-1:0];
        bus.claim_en  = ($urandom_range(0, 2) == 0);
        bus.claim_sel = ($urandom_range(0, 2) == 0) ? bus.write_sel[SW-1:0] : SW'($urandom_range(0, NR - 1));
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("busy_on_reset", 64'(bus.busy), 64'(1));
        repeat (cycles) cycle();
        rst_n = 1'b1;
    endtask

    task automatic peek(input int sel, input logic [DW-1:0] exp_d, input logic exp_p, input string tag);
        set_idle();
        bus.read_sel[SW-1:0] = SW'(sel);
        cycle();
        check(tag, 64'(obs_data0), 64'(exp_d));
        check({tag, "_pending"}, 64'(obs_pend0), 64'(exp_p));
    endtask

    task automatic peek_all_zero(input string tag);
        for (int r = 0; r < NR; r++) peek(r, '0, 1'b0, $sformatf("%s_r%0d", tag, r));
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        do_reset(2);

        // Clear restarted at index 8 with writes/claims offered during the clear.
        repeat (7) cycle();
        rand_inputs();
        do_reset(1);
        repeat (NR - 1) begin
            rand_inputs();
            cycle();
        end
        peek_all_zero("after_clear");

        set_idle();
        bus.write_en   = 2'b01;
        bus.write_sel[SW-1:0] = SW'(3);
        bus.write_data[DW-1:0] = 32'hDEADBEEF;
        bus.read_sel[SW-1:0] = SW'(3);
        cycle();
        check("bypass_r3", 64'(obs_data0), 64'(32'hDEADBEEF));
        peek(3, 32'hDEADBEEF, 1'b0, "reg3");

        set_idle();
        bus.write_en   = 2'b11;
        bus.write_sel  = {SW'(5), SW'(5)};
        bus.write_data = {32'h22222222, 32'h11111111};
        cycle();
        peek(5, 32'h22222222, 1'b0, "reg5_collision");

        set_idle();
        bus.write_en   = 2'b01;
        bus.write_data[DW-1:0] = 32'hFFFFFFFF;
        cycle();
        peek(0, '0, 1'b0, "reg0_write");

        set_idle();
        bus.claim_en  = 1'b1;
        bus.claim_sel = SW'(7);
        cycle();
        peek(7, '0, 1'b1, "claim7");
        set_idle();
        bus.write_en = 2'b01;
        bus.write_sel[SW-1:0] = SW'(7);
        bus.write_data[DW-1:0] = 32'h00000077;
        cycle();
        peek(7, 32'h00000077, 1'b0, "write7");
        set_idle();
        bus.write_en = 2'b10;
        bus.write_sel[SW +: SW] = SW'(7);
        bus.write_data[DW +: DW] = 32'h00000078;
        bus.claim_en  = 1'b1;
        bus.claim_sel = SW'(7);
        cycle();
        peek(7, 32'h00000078, 1'b1, "claim_write7");
        set_idle();
        bus.claim_en = 1'b1;
        cycle();
        peek(0, '0, 1'b0, "claim0");

        repeat (400) begin
            rand_inputs();
            cycle();
        end

        // Reset in READY with claims outstanding; array must be re-zeroed.
        for (int r = 1; r < NR; r += 2) begin
            set_idle();
            bus.claim_en  = 1'b1;
            bus.claim_sel = SW'(r);
            bus.write_en  = 2'b10;
            bus.write_sel[SW +: SW] = SW'(r);
            bus.write_data[DW +: DW] = DW'($urandom) | 32'h1;
            cycle();
        end
        rand_inputs();
        do_reset(2);
        repeat (NR - 1) begin
            rand_inputs();
            cycle();
        end
        peek_all_zero("after_ready_reset");

        repeat (200) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
